// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in
// over a 2^(GATE_LOG2_MIN+gate_sel) cycle window, single-shot or continuous.
module freq_meter #(
  parameter int CNT_W         = 32,
  parameter int GATE_LOG2_MIN = 10,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  input  logic [3:0]       gate_sel,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int GW = GATE_LOG2_MIN + 16;
  localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [GW-1:0]    G_ONE  = {{(GW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEAS,
    S_DONE
  } state_t;

  state_t r_state;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_edge;
  logic [GW-1:0]          r_gate;
  logic [3:0]             r_gsel;
  logic                   r_ovf;

  logic                   w_edge;
  logic                   w_sat;
  logic                   w_last;
  logic [GW-1:0]          w_lastcnt;
  logic [CNT_W-1:0]       w_edge_nxt;
  logic                   w_ovf_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_sat  = &r_edge;

  // Low GATE_LOG2_MIN+gsel bits set: the gate_cnt value of the final cycle.
  assign w_lastcnt = ~({GW{1'b1}} << (GATE_LOG2_MIN + int'(r_gsel)));
  assign w_last    = (r_gate == w_lastcnt);

  always_comb begin
    w_edge_nxt = r_edge;
    w_ovf_nxt  = r_ovf;
    if (w_edge) begin
      if (w_sat) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_edge_nxt = r_edge + C_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_edge      <= '0;
      r_gate      <= '0;
      r_gsel      <= '0;
      r_ovf       <= 1'b0;
      count_out   <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          count_valid <= 1'b0;
          if (start || continuous) begin
            r_gsel  <= gate_sel;
            busy    <= 1'b1;
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          r_edge  <= '0;
          r_gate  <= '0;
          r_ovf   <= 1'b0;
          r_state <= S_MEAS;
        end
        S_MEAS: begin
          r_gate <= r_gate + G_ONE;
          r_edge <= w_edge_nxt;
          r_ovf  <= w_ovf_nxt;
          if (w_last) begin
            count_out   <= w_edge_nxt;
            overflow    <= w_ovf_nxt;
            count_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          count_valid <= 1'b0;
          if (continuous) begin
            r_gsel  <= gate_sel;
            r_state <= S_ARM;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
